// File: rtl/pong_pkg.sv
// Shared types and constants for the pong round/score sequencer.
// Holds the state enum, screen constants, winner encodings and a state helper.
package pong_pkg;

    localparam int unsigned X_W     = 10;
    localparam int unsigned SCORE_W = 4;
    localparam int unsigned CNT_W   = 8;

    localparam int unsigned H_ACTIVE = 640;
    localparam int unsigned V_ACTIVE = 480;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SERVE     = 3'd1,
        ST_PLAY      = 3'd2,
        ST_POINT     = 3'd3,
        ST_GAME_OVER = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        WIN_NONE  = 2'b00,
        WIN_LEFT  = 2'b01,
        WIN_RIGHT = 2'b10
    } winner_e;

    // States in which an in-progress round can be frozen by pause.
    function automatic logic is_active_round(input state_e s);
        return (s == ST_SERVE) || (s == ST_PLAY) || (s == ST_POINT);
    endfunction

endpackage

// File: rtl/pong_game_ctrl_if.sv
// Bus between the pong sequencer and its surroundings (VGA timing, ball, paddles).
// slave  : the sequencer (samples frame/start/clear/ball x, drives control and score).
// master : the environment driving the sequencer.
// Optional pause input exists only when PONG_PAUSE_EN is defined.
interface pong_game_ctrl_if;
    import pong_pkg::*;

    logic               frame_tick;
    logic               start_btn;
    logic               score_clr;
    logic [X_W-1:0]     ball_x_pos;
`ifdef PONG_PAUSE_EN
    logic               pause;
`endif
    logic               ball_hold;
    logic               ball_run;
    logic               paddles_en;
    logic               serve_dir;
    logic [SCORE_W-1:0] score_left;
    logic [SCORE_W-1:0] score_right;
    logic [1:0]         winner;
    logic [2:0]         state_o;

    modport slave (
        input  frame_tick, start_btn, score_clr, ball_x_pos,
`ifdef PONG_PAUSE_EN
        input  pause,
`endif
        output ball_hold, ball_run, paddles_en, serve_dir,
        output score_left, score_right, winner, state_o
    );

    modport master (
        output frame_tick, start_btn, score_clr, ball_x_pos,
`ifdef PONG_PAUSE_EN
        output pause,
`endif
        input  ball_hold, ball_run, paddles_en, serve_dir,
        input  score_left, score_right, winner, state_o
    );

endinterface

// File: rtl/pong_game_ctrl_frame_delay_counter.sv
// 8-bit loadable frame down-counter.
// Ports: clk, reset (sync, active-high), load/load_val (load wins over tick),
//        tick (decrement strobe), done = tick while count is zero.
module frame_delay_counter
    import pong_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             tick,
    output logic             done
);

    logic [CNT_W-1:0] count;

    // Count saturates at zero so a long-idle counter never wraps.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (tick && (count != '0)) begin
            count <= CNT_W'(count - CNT_W'(1));
        end
    end

    assign done = tick & (count == '0);

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong round/score sequencer: IDLE -> SERVE -> PLAY -> POINT -> (SERVE | GAME_OVER).
// Ports: clk, reset (sync, active-high), bus (pong_game_ctrl_if.slave):
//   in : frame_tick, start_btn, score_clr, ball_x_pos (+ pause with PONG_PAUSE_EN)
//   out: ball_hold, ball_run, paddles_en, serve_dir, score_left, score_right,
//        winner, state_o -- all registered.
// Optional feature macro: PONG_PAUSE_EN.
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter logic [X_W-1:0]     LEFT_GOAL_X  = 10'd8,
    parameter logic [X_W-1:0]     RIGHT_GOAL_X = 10'd632,
    parameter logic [CNT_W-1:0]   SERVE_FRAMES = 8'd60,
    parameter logic [CNT_W-1:0]   POINT_FRAMES = 8'd90,
    parameter logic [SCORE_W-1:0] WIN_SCORE    = 4'd7
)(
    input  logic              clk,
    input  logic              reset,
    pong_game_ctrl_if.slave   bus
);

    localparam logic [CNT_W-1:0] SERVE_LOAD = CNT_W'(SERVE_FRAMES - CNT_W'(1));
    localparam logic [CNT_W-1:0] POINT_LOAD = CNT_W'(POINT_FRAMES - CNT_W'(1));

    state_e             state, state_n;
    logic [SCORE_W-1:0] score_l, score_l_n;
    logic [SCORE_W-1:0] score_r, score_r_n;
    winner_e            winner, winner_n;
    logic               serve_dir, serve_dir_n;
    logic               start_q;
    logic               hold_q, hold_n;
    logic               run_q, run_n;
    logic               paddles_q, paddles_n;

    logic               start_rise;
    logic               pause_in;
    logic               paused;
    logic               tick_eff;
    logic               cnt_load;
    logic [CNT_W-1:0]   cnt_val;
    logic               cnt_done;

`ifdef PONG_PAUSE_EN
    assign pause_in = bus.pause;
`else
    assign pause_in = 1'b0;
`endif

    assign start_rise = bus.start_btn & ~start_q;
    assign paused     = pause_in & is_active_round(state);
    // A paused round sees no frame ticks, so its countdown freezes.
    assign tick_eff   = bus.frame_tick & ~paused;

    frame_delay_counter u_frame_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (cnt_val),
        .tick     (tick_eff),
        .done     (cnt_done)
    );

    // State, score and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            score_l   <= '0;
            score_r   <= '0;
            winner    <= WIN_NONE;
            serve_dir <= 1'b1;
            start_q   <= 1'b0;
            hold_q    <= 1'b1;
            run_q     <= 1'b0;
            paddles_q <= 1'b0;
        end else begin
            state     <= state_n;
            score_l   <= score_l_n;
            score_r   <= score_r_n;
            winner    <= winner_n;
            serve_dir <= serve_dir_n;
            start_q   <= bus.start_btn;
            hold_q    <= hold_n;
            run_q     <= run_n;
            paddles_q <= paddles_n;
        end
    end

    // Next-state, score and next-output logic.
    always_comb begin
        state_n     = state;
        score_l_n   = score_l;
        score_r_n   = score_r;
        winner_n    = winner;
        serve_dir_n = serve_dir;
        cnt_load    = 1'b0;
        cnt_val     = SERVE_LOAD;

        unique case (state)
            ST_IDLE: begin
                if (start_rise) begin
                    state_n   = ST_SERVE;
                    score_l_n = '0;
                    score_r_n = '0;
                    cnt_load  = 1'b1;
                    cnt_val   = SERVE_LOAD;
                end
            end
            ST_SERVE: begin
                if (cnt_done) begin
                    state_n = ST_PLAY;
                end
            end
            ST_PLAY: begin
                // Left-goal check first so a misconfigured overlap credits the right player.
                if (!paused) begin
                    if (bus.ball_x_pos <= LEFT_GOAL_X) begin
                        score_r_n   = SCORE_W'(score_r + SCORE_W'(1));
                        serve_dir_n = 1'b0;
                        state_n     = ST_POINT;
                        cnt_load    = 1'b1;
                        cnt_val     = POINT_LOAD;
                    end else if (bus.ball_x_pos >= RIGHT_GOAL_X) begin
                        score_l_n   = SCORE_W'(score_l + SCORE_W'(1));
                        serve_dir_n = 1'b1;
                        state_n     = ST_POINT;
                        cnt_load    = 1'b1;
                        cnt_val     = POINT_LOAD;
                    end
                end
            end
            ST_POINT: begin
                if (cnt_done) begin
                    if (score_l == WIN_SCORE) begin
                        winner_n = WIN_LEFT;
                        state_n  = ST_GAME_OVER;
                    end else if (score_r == WIN_SCORE) begin
                        winner_n = WIN_RIGHT;
                        state_n  = ST_GAME_OVER;
                    end else begin
                        state_n  = ST_SERVE;
                        cnt_load = 1'b1;
                        cnt_val  = SERVE_LOAD;
                    end
                end
            end
            ST_GAME_OVER: begin
                if (start_rise) begin
                    state_n   = ST_SERVE;
                    score_l_n = '0;
                    score_r_n = '0;
                    winner_n  = WIN_NONE;
                    cnt_load  = 1'b1;
                    cnt_val   = SERVE_LOAD;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase

        // Clear overrides every transition above; only reset outranks it.
        if (bus.score_clr) begin
            state_n   = ST_IDLE;
            score_l_n = '0;
            score_r_n = '0;
            winner_n  = WIN_NONE;
            cnt_load  = 1'b0;
        end

        hold_n    = (state_n != ST_PLAY);
        run_n     = (state_n == ST_PLAY) & ~pause_in;
        paddles_n = ((state_n == ST_SERVE) || (state_n == ST_PLAY)) & ~pause_in;
    end

    assign bus.ball_hold   = hold_q;
    assign bus.ball_run    = run_q;
    assign bus.paddles_en  = paddles_q;
    assign bus.serve_dir   = serve_dir;
    assign bus.score_left  = score_l;
    assign bus.score_right = score_r;
    assign bus.winner      = winner;
    assign bus.state_o     = state;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed self-checking bench for pong_game_ctrl.
module tb_pong_game_ctrl;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    pong_game_ctrl_if bus ();

    pong_game_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            bus.frame_tick = 1'b1;
            cyc();
            bus.frame_tick = 1'b0;
            cyc();
        end
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // From POINT: wait out the freeze, then the serve, back to PLAY.
    task automatic point_to_play();
        bus.ball_x_pos = 10'd320;
        ticks(90);
        ticks(60);
    endtask

    task automatic goal(input logic [9:0] x);
        bus.ball_x_pos = x;
        cyc();
        point_to_play();
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset          = 1'b1;
        bus.frame_tick = 1'b0;
        bus.start_btn  = 1'b0;
        bus.score_clr  = 1'b0;
        bus.ball_x_pos = 10'd320;
`ifdef PONG_PAUSE_EN
        bus.pause      = 1'b0;
`endif
        cyc();
        cyc();
        reset = 1'b0;
        cyc();

        // Reset state
        chk("rst_state",   16'(bus.state_o), 16'd0);
        chk("rst_hold",    16'(bus.ball_hold), 16'd1);
        chk("rst_run",     16'(bus.ball_run), 16'd0);
        chk("rst_paddles", 16'(bus.paddles_en), 16'd0);
        chk("rst_dir",     16'(bus.serve_dir), 16'd1);
        chk("rst_sl",      16'(bus.score_left), 16'd0);
        chk("rst_sr",      16'(bus.score_right), 16'd0);
        chk("rst_winner",  16'(bus.winner), 16'd0);

        // Serve timing: exactly 60 ticks
        bus.start_btn = 1'b1;
        cyc();
        bus.start_btn = 1'b0;
        chk("serve_state",   16'(bus.state_o), 16'd1);
        chk("serve_paddles", 16'(bus.paddles_en), 16'd1);
        chk("serve_hold",    16'(bus.ball_hold), 16'd1);
        ticks(59);
        chk("serve_59",      16'(bus.state_o), 16'd1);
        chk("serve_59_run",  16'(bus.ball_run), 16'd0);
        ticks(1);
        chk("play_state",    16'(bus.state_o), 16'd2);
        chk("play_run",      16'(bus.ball_run), 16'd1);
        chk("play_hold",     16'(bus.ball_hold), 16'd0);

        // Near-boundary positions are not goals
        bus.ball_x_pos = 10'd9;
        cyc();
        bus.ball_x_pos = 10'd631;
        cyc();
        chk("no_goal_state", 16'(bus.state_o), 16'd2);
        chk("no_goal_sr",    16'(bus.score_right), 16'd0);

        // Right-player point, held ball counts once
        bus.ball_x_pos = 10'd5;
        cyc();
        chk("rpt_sr",      16'(bus.score_right), 16'd1);
        chk("rpt_dir",     16'(bus.serve_dir), 16'd0);
        chk("rpt_state",   16'(bus.state_o), 16'd3);
        chk("rpt_hold",    16'(bus.ball_hold), 16'd1);
        chk("rpt_paddles", 16'(bus.paddles_en), 16'd0);
        ticks(89);
        chk("rpt_89",      16'(bus.state_o), 16'd3);
        ticks(1);
        chk("rpt_serve",   16'(bus.state_o), 16'd1);
        chk("rpt_once",    16'(bus.score_right), 16'd1);
        bus.ball_x_pos = 10'd320;
        ticks(60);
        chk("rpt_play",    16'(bus.state_o), 16'd2);

        // Left goals to WIN_SCORE
        for (int g = 0; g < 6; g++) goal(10'd635);
        chk("left6_sl", 16'(bus.score_left), 16'd6);
        bus.ball_x_pos = 10'd635;
        cyc();
        chk("left7_sl",    16'(bus.score_left), 16'd7);
        chk("left7_dir",   16'(bus.serve_dir), 16'd1);
        chk("left7_state", 16'(bus.state_o), 16'd3);
        bus.ball_x_pos = 10'd320;
        ticks(89);
        chk("left7_89",    16'(bus.state_o), 16'd3);
        ticks(1);
        chk("go_state",    16'(bus.state_o), 16'd4);
        chk("go_winner",   16'(bus.winner), 16'd1);
        chk("go_sr",       16'(bus.score_right), 16'd1);
        chk("go_hold",     16'(bus.ball_hold), 16'd1);
        ticks(3);
        chk("go_stays",    16'(bus.state_o), 16'd4);

        // Restart from GAME_OVER, start kept high afterwards
        bus.start_btn = 1'b1;
        cyc();
        chk("restart_state",  16'(bus.state_o), 16'd1);
        chk("restart_sl",     16'(bus.score_left), 16'd0);
        chk("restart_sr",     16'(bus.score_right), 16'd0);
        chk("restart_winner", 16'(bus.winner), 16'd0);

        // Clear mid-serve, held start must not re-serve from IDLE
        ticks(10);
        bus.score_clr = 1'b1;
        cyc();
        bus.score_clr = 1'b0;
        chk("clr_serve_state", 16'(bus.state_o), 16'd0);
        ticks(3);
        chk("held_idle",       16'(bus.state_o), 16'd0);
        bus.start_btn = 1'b0;
        cyc();
        chk("fall_idle",       16'(bus.state_o), 16'd0);
        bus.start_btn = 1'b1;
        cyc();
        bus.start_btn = 1'b0;
        chk("rise_serve",      16'(bus.state_o), 16'd1);
        ticks(60);
        chk("play2_state",     16'(bus.state_o), 16'd2);

        // Build 3/2 at exact goal boundaries, right goal last
        goal(10'd632);
        goal(10'd632);
        goal(10'd8);
        goal(10'd632);
        goal(10'd8);
        chk("pre_clr_sl",  16'(bus.score_left), 16'd3);
        chk("pre_clr_sr",  16'(bus.score_right), 16'd2);
        chk("pre_clr_dir", 16'(bus.serve_dir), 16'd0);

        // Clear in PLAY beats a same-cycle goal
        bus.ball_x_pos = 10'd635;
        bus.score_clr  = 1'b1;
        cyc();
        bus.score_clr  = 1'b0;
        bus.ball_x_pos = 10'd320;
        chk("clr_state",  16'(bus.state_o), 16'd0);
        chk("clr_sl",     16'(bus.score_left), 16'd0);
        chk("clr_sr",     16'(bus.score_right), 16'd0);
        chk("clr_run",    16'(bus.ball_run), 16'd0);
        chk("clr_hold",   16'(bus.ball_hold), 16'd1);

        // reset and score_clr together give reset values
        bus.start_btn = 1'b1;
        cyc();
        bus.start_btn = 1'b0;
        ticks(60);
        bus.ball_x_pos = 10'd3;
        cyc();
        bus.ball_x_pos = 10'd320;
        chk("pre_rst_dir", 16'(bus.serve_dir), 16'd0);
        chk("pre_rst_sr",  16'(bus.score_right), 16'd1);
        reset         = 1'b1;
        bus.score_clr = 1'b1;
        cyc();
        reset         = 1'b0;
        bus.score_clr = 1'b0;
        chk("rc_state", 16'(bus.state_o), 16'd0);
        chk("rc_dir",   16'(bus.serve_dir), 16'd1);
        chk("rc_sr",    16'(bus.score_right), 16'd0);
        chk("rc_hold",  16'(bus.ball_hold), 16'd1);

`ifdef PONG_PAUSE_EN
        // Pause 20 ticks midway through SERVE
        bus.start_btn = 1'b1;
        cyc();
        bus.start_btn = 1'b0;
        ticks(30);
        bus.pause = 1'b1;
        cyc();
        chk("pause_paddles", 16'(bus.paddles_en), 16'd0);
        ticks(20);
        chk("pause_state",   16'(bus.state_o), 16'd1);
        chk("pause_run",     16'(bus.ball_run), 16'd0);
        bus.pause = 1'b0;
        cyc();
        chk("unpause_paddles", 16'(bus.paddles_en), 16'd1);
        ticks(29);
        chk("pause_59",      16'(bus.state_o), 16'd1);
        ticks(1);
        chk("pause_play",    16'(bus.state_o), 16'd2);
        chk("pause_play_run", 16'(bus.ball_run), 16'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pong_game_ctrl.md
Name: pong_game_ctrl

Overview:
- Round/score sequencer for the pong datapath. Decides when the ball is held at centre and when it runs, and when paddles may move.
- Detects goals from the ball's x position, keeps both scores, applies win detection, and sequences IDLE -> SERVE -> PLAY -> POINT -> (SERVE | GAME_OVER).
- Sits between the VGA timing (frame tick from the vertical counter) and the ball/paddle blocks; replaces ad-hoc end-of-round reset gating.

Parameters:
- LEFT_GOAL_X, 10'd8: ball_x_pos <= this in PLAY is a right-player point.
- RIGHT_GOAL_X, 10'd632: ball_x_pos >= this in PLAY is a left-player point.
- SERVE_FRAMES, 8'd60: frames the ball is held before release; legal range 1..255.
- POINT_FRAMES, 8'd90: freeze frames after a goal; legal range 1..255.
- WIN_SCORE, 4'd7: score that ends the game; legal range 1..15.

Ports:
- clk, input, 1: pixel clock.
- reset, input, 1: synchronous, active-high; has priority over all other inputs.
- frame_tick, input, 1: one-cycle pulse per frame.
- start_btn, input, 1: level, already synchronised; only rising edges act.
- score_clr, input, 1: synchronous clear of the game.
- ball_x_pos, input, 10: ball centre x.
- ball_hold, output, 1: ball block holds the ball at centre.
- ball_run, output, 1: ball may move.
- paddles_en, output, 1: paddle movement allowed.
- serve_dir, output, 1: 1 = serve toward the right player, 0 = toward the left.
- score_left, output, 4: left player score.
- score_right, output, 4: right player score.
- winner, output, 2: 00 = none, 01 = left, 10 = right.
- state_o, output, 3: current state encoding, for debug/overlay.

Behaviour:
- Registered outputs: every output reflects the state register, so there is 1 cycle of latency from the causing input.
- Reset values:
  - state = IDLE; ball_hold = 1; ball_run = 0; paddles_en = 0.
  - serve_dir = 1; score_left = score_right = 0; winner = 00.
  - start edge-detect register = 0; frame counter = 0.
- Rising-edge detect: start_rise = start_btn & ~start_q, with start_q registered every cycle.
- Frame counter: 8-bit down-counter. It is loaded with N-1 on state entry and decremented only on frame_tick. Expiry means frame_tick while the count is 0, so the state lasts exactly N frame ticks.
- Per-state outputs:
  - IDLE: ball_hold = 1, paddles_en = 0. start_rise -> SERVE; scores cleared, counter loaded with SERVE_FRAMES-1.
  - SERVE: ball_hold = 1, paddles_en = 1. On expiry -> PLAY.
  - PLAY: ball_run = 1, ball_hold = 0, paddles_en = 1.
    - ball_x_pos <= LEFT_GOAL_X: score_right += 1, serve_dir = 0 (serve to the conceding player), go to POINT.
    - ball_x_pos >= RIGHT_GOAL_X: score_left += 1, serve_dir = 1, go to POINT.
    - Both conditions true (parameter misconfiguration): the left-goal check wins.
    - A goal is counted once per entry into PLAY.
  - POINT: ball_hold = 1, paddles_en = 0, counter loaded with POINT_FRAMES-1. On expiry:
    - If score_left == WIN_SCORE: winner = 01, go to GAME_OVER.
    - Else if score_right == WIN_SCORE: winner = 10, go to GAME_OVER.
    - Else go to SERVE.
  - GAME_OVER: ball_hold = 1, paddles_en = 0, scores frozen. start_rise -> scores and winner cleared, go to SERVE.
- score_clr:
  - In any state (and mid-countdown), the next cycle has state = IDLE, scores = 0, winner = 00.
  - Lower priority than reset; higher priority than goals, expiry and start.
- Arithmetic: scores never exceed WIN_SCORE (increments happen only in PLAY). No wrap is needed.
- start_btn held high: at most one transition per rising edge.

Optional Feature:
- Macro: PONG_PAUSE_EN.
- When defined:
  - Adds input pause (level).
  - While pause = 1 in SERVE, PLAY or POINT: the frame counter does not decrement, goals are ignored, and ball_run = paddles_en = 0.
  - State and scores hold; outputs resume on the cycle after pause falls.
  - reset and score_clr still act during pause.
- When undefined: there is no pause port, and behaviour is exactly as above.

Decomposition:
- Shared package pong_pkg holds:
  - The state enum (IDLE = 0, SERVE = 1, PLAY = 2, POINT = 3, GAME_OVER = 4).
  - Screen constants (H_ACTIVE = 640, V_ACTIVE = 480).
  - The winner encodings.
- One sub-module: frame_delay_counter, an 8-bit loadable down-counter.
  - Inputs: load, load_val, tick.
  - Output: done = tick & (count == 0).

Test Plan:
- Serve timing: reset, then start_btn 0->1 -> SERVE. Apply 60 frame_ticks -> state_o = PLAY and ball_run = 1 on the cycle after the 60th tick, not the 59th.
- Right-player point: in PLAY, ball_x_pos = 5 -> score_right 0->1, serve_dir = 0, state POINT, ball_hold = 1. Holding ball_x_pos = 5 for 90 ticks increments the score only once.
- Game over: drive left goals (ball_x_pos = 635) until score_left = 7, then 90 ticks -> GAME_OVER, winner = 01. A further start rising edge -> SERVE with scores 0 and winner 00.
- Clear in PLAY: score_clr asserted with scores 3/2 -> next cycle IDLE, both scores 0. Same-cycle goal is ignored.
- Held start: start_btn held high across GAME_OVER and IDLE -> no transition until it falls and rises again. reset and score_clr asserted together -> reset values.
- Pause (PONG_PAUSE_EN): pause high for 20 ticks midway through SERVE -> PLAY entry delayed by exactly 20 ticks; ball_run = 0 throughout the pause.
